// File: rtl/axis_loop_pkg.sv
// Shared types and the per-beat data transform for the AXI-Stream loopback core.
package axis_loop_pkg;

  // Widest stream the transform helper supports; callers cast in and out.
  localparam int MAX_TDATA_W = 1024;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_ADD  = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_INV  = 2'b11
  } loop_mode_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } in_state_t;

  // Low bits of the result are exact for any narrower width (add drops carry).
  function automatic logic [MAX_TDATA_W-1:0] apply_transform(
    input loop_mode_t                 mode,
    input logic [MAX_TDATA_W-1:0]     operand,
    input logic [MAX_TDATA_W-1:0]     data
  );
    logic [MAX_TDATA_W-1:0] result;
    case (mode)
      MODE_PASS: result = data;
      MODE_ADD:  result = data + operand;
      MODE_XOR:  result = data ^ operand;
      MODE_INV:  result = ~data;
      default:   result = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/axis_loop_fifo.sv
// Synchronous FIFO whose head entry is presented from a register stage;
// capacity DEPTH counts the presented entry, level is registered.
module axis_loop_fifo
  import axis_loop_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      wr_ptr_nxt_s;
  logic [AW:0]      rd_ptr_nxt_s;
  logic             wr_fire_s;
  logic             rd_fire_s;
  logic [WIDTH-1:0] head_nxt_s;
  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic [AW:0]      level_r;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign wr_fire_s = wr_en && !full;
  assign rd_fire_s = valid_r && rd_ready;
  assign rd_data   = data_r;
  assign rd_valid  = valid_r;
  assign level     = level_r;

  // Next pointers and the entry that will sit at the head after this edge.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    head_nxt_s   = '0;
    if (wr_fire_s) begin
      wr_ptr_nxt_s = wr_ptr_r + (AW+1)'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (rd_fire_s) begin
      rd_ptr_nxt_s = rd_ptr_r + (AW+1)'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    // The new head is the beat being written when it lands in an emptied FIFO.
    if (wr_fire_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = wr_data;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_fire_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Pointers, registered head stage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      data_r   <= '0;
      valid_r  <= 1'b0;
      level_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      data_r   <= head_nxt_s;
      valid_r  <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
      level_r  <= wr_ptr_nxt_s - rd_ptr_nxt_s;
    end
  end

endmodule

// File: rtl/axis_loop_core.sv
// AXI-Stream loopback: transforms input beats with a per-packet latched
// operation, buffers them and returns them on M_AXIS with status counters.
module axis_loop_core
  import axis_loop_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH         = 16,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              cfg_enable,
  input  logic [1:0]                        cfg_mode,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     cfg_operand,
  input  logic                              clr_counters,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0]   S_AXIS_TKEEP,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  output logic [C_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic [CNT_WIDTH-1:0]              stat_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              stat_beat_cnt,
  output logic [$clog2(FIFO_DEPTH):0]       stat_fifo_level,
  output logic                              stat_in_pkt
);

  localparam int DW = C_AXIS_TDATA_WIDTH;
  localparam int KW = C_AXIS_TDATA_WIDTH / 8;
  localparam int FW = DW + KW + 1;

  in_state_t              state_r;
  loop_mode_t             mode_lat_r;
  logic [DW-1:0]          operand_lat_r;
  loop_mode_t             mode_s;
  logic [DW-1:0]          operand_s;
  logic [DW-1:0]          xf_data_s;
  logic                   in_fire_s;
  logic                   out_fire_s;
  logic                   fifo_full_s;
  logic [FW-1:0]          fifo_wr_s;
  logic [FW-1:0]          fifo_rd_s;
  logic [CNT_WIDTH-1:0]   pkt_cnt_r;
  logic [CNT_WIDTH-1:0]   beat_cnt_r;

  assign S_AXIS_TREADY = cfg_enable && !fifo_full_s;
  assign in_fire_s     = S_AXIS_TVALID && S_AXIS_TREADY;
  assign out_fire_s    = M_AXIS_TVALID && M_AXIS_TREADY;
  assign stat_in_pkt   = (state_r == IN_PKT);
  assign stat_pkt_cnt  = pkt_cnt_r;
  assign stat_beat_cnt = beat_cnt_r;

  // First beat of a packet sees the live config; later beats the latched copy.
  always_comb begin
    mode_s    = MODE_PASS;
    operand_s = '0;
    if (state_r == IN_PKT) begin
      mode_s    = mode_lat_r;
      operand_s = operand_lat_r;
    end else begin
      mode_s    = loop_mode_t'(cfg_mode);
      operand_s = cfg_operand;
    end
    xf_data_s = DW'(apply_transform(mode_s, MAX_TDATA_W'(operand_s),
                                    MAX_TDATA_W'(S_AXIS_TDATA)));
    fifo_wr_s = {xf_data_s, S_AXIS_TKEEP, S_AXIS_TLAST};
  end

  // Packet-tracking FSM and config latch.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r       <= IDLE;
      mode_lat_r    <= MODE_PASS;
      operand_lat_r <= '0;
    end else if (in_fire_s) begin
      case (state_r)
        IDLE: begin
          if (!S_AXIS_TLAST) begin
            state_r       <= IN_PKT;
            mode_lat_r    <= loop_mode_t'(cfg_mode);
            operand_lat_r <= cfg_operand;
          end
        end
        IN_PKT: begin
          if (S_AXIS_TLAST) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Output-side status counters; a clear beats a coincident increment.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pkt_cnt_r  <= '0;
      beat_cnt_r <= '0;
    end else if (clr_counters) begin
      pkt_cnt_r  <= '0;
      beat_cnt_r <= '0;
    end else if (out_fire_s) begin
      beat_cnt_r <= beat_cnt_r + CNT_WIDTH'(1);
      if (M_AXIS_TLAST) begin
        pkt_cnt_r <= pkt_cnt_r + CNT_WIDTH'(1);
      end
    end
  end

  axis_loop_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .wr_data  (fifo_wr_s),
    .wr_en    (in_fire_s),
    .full     (fifo_full_s),
    .rd_data  (fifo_rd_s),
    .rd_valid (M_AXIS_TVALID),
    .rd_ready (M_AXIS_TREADY),
    .level    (stat_fifo_level)
  );

  assign M_AXIS_TDATA = fifo_rd_s[FW-1:KW+1];
  assign M_AXIS_TKEEP = fifo_rd_s[KW:1];
  assign M_AXIS_TLAST = fifo_rd_s[0];

endmodule
